// File: rtl/enigma_pkg.sv
// Shared Enigma datapath types and constants: letter indices, one-hot letters
// and the plugboard FSM encoding.
package enigma_pkg;

  localparam int NUM_LETTERS = 26;
  localparam int MAX_PAIRS   = 10;

  typedef logic [4:0]             letter_idx_t;
  typedef logic [NUM_LETTERS-1:0] letter_oh_t;

  localparam letter_idx_t IDX_A = 5'd0;
  localparam letter_idx_t IDX_B = 5'd1;
  localparam letter_idx_t IDX_C = 5'd2;
  localparam letter_idx_t IDX_D = 5'd3;
  localparam letter_idx_t IDX_E = 5'd4;
  localparam letter_idx_t IDX_F = 5'd5;
  localparam letter_idx_t IDX_G = 5'd6;
  localparam letter_idx_t IDX_H = 5'd7;
  localparam letter_idx_t IDX_I = 5'd8;
  localparam letter_idx_t IDX_J = 5'd9;
  localparam letter_idx_t IDX_K = 5'd10;
  localparam letter_idx_t IDX_L = 5'd11;
  localparam letter_idx_t IDX_M = 5'd12;
  localparam letter_idx_t IDX_N = 5'd13;
  localparam letter_idx_t IDX_O = 5'd14;
  localparam letter_idx_t IDX_P = 5'd15;
  localparam letter_idx_t IDX_Q = 5'd16;
  localparam letter_idx_t IDX_R = 5'd17;
  localparam letter_idx_t IDX_S = 5'd18;
  localparam letter_idx_t IDX_T = 5'd19;
  localparam letter_idx_t IDX_U = 5'd20;
  localparam letter_idx_t IDX_V = 5'd21;
  localparam letter_idx_t IDX_W = 5'd22;
  localparam letter_idx_t IDX_X = 5'd23;
  localparam letter_idx_t IDX_Y = 5'd24;
  localparam letter_idx_t IDX_Z = 5'd25;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_P_FIRST  = 2'd1;
  localparam logic [1:0] ST_P_SECOND = 2'd2;

endpackage

// File: rtl/onehot26_enc.sv
// One-hot letter to 5-bit index; legal is high only when exactly one bit is set.
module onehot26_enc
  import enigma_pkg::*;
(
  input  letter_oh_t  oh,
  output letter_idx_t idx,
  output logic        legal
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (oh[i]) idx = idx | letter_idx_t'(i);
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit word.
  assign legal = (oh != '0) && ((oh & (oh - letter_oh_t'(1))) == '0);

endmodule

// File: rtl/plugboard_stage.sv
// Programmable Enigma plugboard: pairs are entered letter-by-letter in program
// mode and applied as a symmetric swap table in run mode.
module plugboard_stage
  import enigma_pkg::*;
(
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NUM_LETTERS-1:0] in_letter,
  input  logic                   in_valid,
  input  logic                   prog_mode,
  input  logic                   clear,
  output logic [NUM_LETTERS-1:0] out_letter,
  output logic                   out_valid,
  output logic [3:0]             pair_count,
  output logic                   prog_busy,
  output logic                   err
);

  letter_idx_t map_q [NUM_LETTERS];
  letter_idx_t map_d [NUM_LETTERS];
  logic [1:0]  state_q, state_d;
  logic [3:0]  pair_count_q, pair_count_d;
  letter_idx_t first_q, first_d;
  letter_oh_t  out_letter_q, out_letter_d;
  logic        out_valid_q, out_valid_d;
  logic        err_q, err_d;

  letter_idx_t in_idx;
  logic        in_legal;
  logic        mode_switch;

  onehot26_enc u_enc (
    .oh    (in_letter),
    .idx   (in_idx),
    .legal (in_legal)
  );

  // A mode change wins over a key press arriving in the same cycle.
  assign mode_switch = (state_q == ST_RUN) ? prog_mode : !prog_mode;

  always_comb begin
    state_d      = state_q;
    map_d        = map_q;
    pair_count_d = pair_count_q;
    first_d      = first_q;
    out_letter_d = out_letter_q;
    out_valid_d  = 1'b0;
    err_d        = 1'b0;
    if (clear) begin
      for (int i = 0; i < NUM_LETTERS; i++) map_d[i] = letter_idx_t'(i);
      pair_count_d = '0;
      out_letter_d = '0;
      state_d      = prog_mode ? ST_P_FIRST : ST_RUN;
    end else begin
      if (mode_switch) state_d = prog_mode ? ST_P_FIRST : ST_RUN;
      if (in_valid && !in_legal) begin
        err_d = 1'b1;
      end else if (in_valid && !mode_switch) begin
        case (state_q)
          ST_RUN: begin
            out_letter_d = letter_oh_t'(1) << map_q[in_idx];
            out_valid_d  = 1'b1;
          end
          ST_P_FIRST: begin
            if (pair_count_q == 4'(MAX_PAIRS) || map_q[in_idx] != in_idx) begin
              err_d = 1'b1;
            end else begin
              first_d = in_idx;
              state_d = ST_P_SECOND;
            end
          end
          ST_P_SECOND: begin
            if (in_idx == first_q) begin
              state_d = ST_P_FIRST;
            end else if (map_q[in_idx] != in_idx) begin
              err_d = 1'b1;
            end else begin
              map_d[first_q] = in_idx;
              map_d[in_idx]  = first_q;
              pair_count_d   = pair_count_q + 4'd1;
              state_d        = ST_P_FIRST;
            end
          end
          default: state_d = ST_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < NUM_LETTERS; i++) map_q[i] <= letter_idx_t'(i);
      state_q      <= ST_RUN;
      pair_count_q <= '0;
      first_q      <= '0;
      out_letter_q <= '0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      map_q        <= map_d;
      state_q      <= state_d;
      pair_count_q <= pair_count_d;
      first_q      <= first_d;
      out_letter_q <= out_letter_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
    end
  end

  assign out_letter = out_letter_q;
  assign out_valid  = out_valid_q;
  assign pair_count = pair_count_q;
  assign prog_busy  = (state_q == ST_P_SECOND);
  assign err        = err_q;

endmodule

// File: tb/tb_plugboard_stage.sv
// Self-checking bench for plugboard_stage against a swap-table reference model.
module tb_plugboard_stage;

  logic        CLOCK_50 = 1'b0;
  logic        reset, in_valid, prog_mode, clear;
  logic [25:0] in_letter;
  logic [25:0] out_letter;
  logic        out_valid, prog_busy, err;
  logic [3:0]  pair_count;

  int checks = 0;
  int errors = 0;

  // Reference model: plug table as a plain array plus the pending first letter.
  int m_map [26];
  int m_count;
  bit m_pending;
  int m_first;

  plugboard_stage dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .in_letter  (in_letter),
    .in_valid   (in_valid),
    .prog_mode  (prog_mode),
    .clear      (clear),
    .out_letter (out_letter),
    .out_valid  (out_valid),
    .pair_count (pair_count),
    .prog_busy  (prog_busy),
    .err        (err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [25:0] oh(int l);
    logic [25:0] one;
    one = 26'd1;
    return one << l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 26; i++) m_map[i] = i;
    m_count   = 0;
    m_pending = 0;
    m_first   = 0;
  endtask

  // Program-mode key press on the model; returns whether it should be rejected.
  task automatic model_prog(input int l, output bit exp_err);
    exp_err = 0;
    if (!m_pending) begin
      if (m_count == 10 || m_map[l] != l) exp_err = 1;
      else begin m_pending = 1; m_first = l; end
    end else begin
      if (l == m_first) m_pending = 0;
      else if (m_map[l] != l) exp_err = 1;
      else begin
        m_map[m_first] = l;
        m_map[l]       = m_first;
        m_count++;
        m_pending = 0;
      end
    end
  endtask

  task automatic press(input logic [25:0] letter);
    @(negedge CLOCK_50);
    in_letter = letter;
    in_valid  = 1'b1;
    @(posedge CLOCK_50);
    #1;
    in_valid  = 1'b0;
  endtask

  task automatic set_mode(input logic m);
    @(negedge CLOCK_50);
    prog_mode = m;
    @(posedge CLOCK_50);
    #1;
    m_pending = 0;
  endtask

  task automatic do_clear();
    @(negedge CLOCK_50);
    clear = 1'b1;
    @(posedge CLOCK_50);
    #1;
    clear = 1'b0;
    model_reset();
  endtask

  task automatic prog_press(input int l, input string tag);
    bit exp_err;
    model_prog(l, exp_err);
    press(oh(l));
    checks++;
    if (err !== exp_err || prog_busy !== m_pending || pair_count !== 4'(m_count) || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s letter=%0d err=%b/%b busy=%b/%b count=%0d/%0d ov=%b/0",
               tag, l, err, exp_err, prog_busy, m_pending, pair_count, m_count, out_valid);
    end else
      $display("prog %s letter=%0d err=%b busy=%b count=%0d", tag, l, err, prog_busy, pair_count);
  endtask

  task automatic run_press(input int l, input string tag);
    press(oh(l));
    checks++;
    if (out_valid !== 1'b1 || out_letter !== oh(m_map[l]) || err !== 1'b0) begin
      errors++;
      $display("FAIL %s letter=%0d out=%h/%h ov=%b err=%b", tag, l, out_letter, oh(m_map[l]), out_valid, err);
    end else
      $display("run %s letter=%0d out=%h", tag, l, out_letter);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_letter = '0; prog_mode = 1'b0; clear = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    model_reset();
    checks++;
    if (out_letter !== 26'd0 || out_valid !== 1'b0 || pair_count !== 4'd0 || prog_busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset out=%h ov=%b count=%0d busy=%b err=%b required 0", out_letter, out_valid, pair_count, prog_busy, err);
    end else $display("reset ok");
  endtask

  task automatic test_run_identity();
    press(26'h10);
    checks++;
    if (out_letter !== 26'h10 || out_valid !== 1'b1 || pair_count !== 4'd0) begin
      errors++;
      $display("FAIL run_E out=%h/10 ov=%b/1 count=%0d/0", out_letter, out_valid, pair_count);
    end else $display("run_E out=%h", out_letter);
    @(posedge CLOCK_50); #1;
    checks++;
    if (out_valid !== 1'b0 || out_letter !== 26'h10) begin
      errors++;
      $display("FAIL run_E_hold ov=%b/0 out=%h/10", out_valid, out_letter);
    end else $display("run_E_hold ov=0");
  endtask

  task automatic test_program_pair();
    set_mode(1'b1);
    prog_press(0, "AQ_first");
    prog_press(16, "AQ_second");
    set_mode(1'b0);
    press(26'h1);
    checks++;
    if (out_letter !== 26'h10000 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL AQ_runA out=%h/10000 ov=%b", out_letter, out_valid);
    end else $display("AQ_runA out=%h", out_letter);
    press(26'h10000);
    checks++;
    if (out_letter !== 26'h1 || pair_count !== 4'd1) begin
      errors++;
      $display("FAIL AQ_runQ out=%h/1 count=%0d/1", out_letter, pair_count);
    end else $display("AQ_runQ out=%h count=%0d", out_letter, pair_count);
  endtask

  task automatic test_prog_errors();
    set_mode(1'b1);
    prog_press(0, "err_A_plugged");
    prog_press(1, "err_B_first");
    prog_press(16, "err_Q_plugged");
    prog_press(1, "err_B_cancel");
    set_mode(1'b0);
    run_press(1, "err_B_unplugged");
  endtask

  task automatic test_full();
    set_mode(1'b1);
    do_clear();
    for (int p = 0; p < 10; p++) begin
      prog_press(2 * p, "full_x");
      prog_press(2 * p + 1, "full_y");
    end
    prog_press(20, "full_reject");
    set_mode(1'b0);
    run_press(7, "full_run");
  endtask

  task automatic test_illegal();
    press(26'h3);
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL illegal ov=%b/0 err=%b/1", out_valid, err);
    end else $display("illegal err=1");
    @(posedge CLOCK_50); #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse err=%b/0", err);
    end else $display("illegal_pulse err=0");
  endtask

  task automatic test_clear_with_valid();
    set_mode(1'b1);
    do_clear();
    prog_press(2, "clr_p"); prog_press(9, "clr_p");
    prog_press(4, "clr_p"); prog_press(11, "clr_p");
    prog_press(20, "clr_p"); prog_press(25, "clr_p");
    set_mode(1'b0);
    run_press(2, "clr_pre");
    @(negedge CLOCK_50);
    clear = 1'b1; in_valid = 1'b1; in_letter = oh(4);
    @(posedge CLOCK_50); #1;
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    checks++;
    if (pair_count !== 4'd0 || out_letter !== 26'd0 || out_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL clear count=%0d/0 out=%h/0 ov=%b/0 err=%b/0", pair_count, out_letter, out_valid, err);
    end else $display("clear ok");
    run_press(2, "clr_id"); run_press(9, "clr_id"); run_press(25, "clr_id");
  endtask

  task automatic test_random_program();
    set_mode(1'b1);
    do_clear();
    for (int k = 0; k < 60; k++) prog_press(int'($urandom_range(0, 25)), "rnd_prog");
    set_mode(1'b0);
  endtask

  task automatic test_back_to_back();
    int l;
    for (int k = 0; k < 40; k++) begin
      l = int'($urandom_range(0, 25));
      @(negedge CLOCK_50);
      in_letter = oh(l);
      in_valid  = 1'b1;
      @(posedge CLOCK_50); #1;
      checks++;
      if (out_valid !== 1'b1 || out_letter !== oh(m_map[l])) begin
        errors++;
        $display("FAIL b2b letter=%0d out=%h/%h ov=%b", l, out_letter, oh(m_map[l]), out_valid);
      end else $display("b2b letter=%0d out=%h", l, out_letter);
    end
    @(negedge CLOCK_50);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_identity();
    test_program_pair();
    test_prog_errors();
    test_full();
    test_illegal();
    test_clear_with_valid();
    test_random_program();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
